fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_pkg.sv | 28 ++
 rtl/fifo_stream_reader_if.sv | 25 ++
 rtl/fifo_stream_reader_stream_buf2.sv | 90 +++++++++
 rtl/fifo_stream_reader.sv | 66 ++++++
 tb/tb_fifo_stream_reader.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg
//   Shared FIFO-reader constants: skid buffer depth, transfer counter width,
//   occupancy state encoding and a ceil(log2) helper.
package fifo_stream_reader_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned OCC_W     = clog2(BUF_DEPTH + 1);

    // Buffer occupancy: number of words currently held
    typedef enum logic [OCC_W-1:0] {
        OCC_S0 = 2'd0,
        OCC_S1 = 2'd1,
        OCC_S2 = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
//   Bundles the upstream FIFO read port and the downstream valid/ready stream.
//   slave  : the reader block (consumes FIFO flags/data, produces the stream)
//   master : the environment (FIFO model plus downstream sink)
//   Signals: fifo_empty, fifo_q, fifo_pop, out_valid, out_ready, out_data
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  fifo_empty, fifo_q, out_ready,
        output fifo_pop, out_valid, out_data
    );

    modport master (
        output fifo_empty, fifo_q, out_ready,
        input  fifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/fifo_stream_reader_stream_buf2.sv
// stream_buf2
//   Two-entry ordered word store. head_q is always the oldest word and drives
//   the output directly, so the visible word comes straight from a register.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     push_i/push_data_i  append a word at the tail
//     pop_i             drop the head word
//     clear_i           discard everything (overrides push/pop)
//     head_o            oldest word
//     occ_o             occupancy state
//     valid_o           occupancy non-zero
module stream_buf2
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] head_o,
    output occ_e             occ_o,
    output logic             valid_o
);

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_S0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (clear_i) begin
            occ_d = OCC_S0;
        end else begin
            unique case (occ_q)
                OCC_S0: begin
                    if (push_i) begin
                        head_d = push_data_i;
                        occ_d  = OCC_S1;
                    end
                end
                OCC_S1: begin
                    case ({push_i, pop_i})
                        2'b10: begin
                            tail_d = push_data_i;
                            occ_d  = OCC_S2;
                        end
                        2'b01: occ_d = OCC_S0;
                        // Replace the leaving head with the arriving word.
                        2'b11: head_d = push_data_i;
                        default: ;
                    endcase
                end
                OCC_S2: begin
                    // Full: a push is only possible alongside a pop.
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) begin
                            tail_d = push_data_i;
                        end else begin
                            occ_d = OCC_S1;
                        end
                    end
                end
                default: occ_d = OCC_S0;
            endcase
        end
    end

    assign head_o  = head_q;
    assign occ_o   = occ_q;
    assign valid_o = (occ_q != OCC_S0);

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Turns a 1-cycle-latency FIFO read port (pop -> q next cycle) into a
//   valid/ready stream, using a 2-entry buffer so a full-rate stream survives
//   downstream stalls without losing words.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     flush       drop buffered and in-flight words
//     xfer_count  completed downstream transfers (wraps)
//     bus         slave side of fifo_stream_reader_if
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic [CNT_W-1:0]      xfer_count,
    fifo_stream_reader_if.slave   bus
);

    logic             inflight_q;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             deq;
    logic             out_valid;
    logic [WIDTH-1:0] head;
    occ_e             occ;
    logic [2:0]       pending;

    stream_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q && !flush),
        .push_data_i (bus.fifo_q),
        .pop_i       (deq),
        .clear_i     (flush),
        .head_o      (head),
        .occ_o       (occ),
        .valid_o     (out_valid)
    );

    assign deq = out_valid && bus.out_ready;

    // Words that will be held after this edge; a new pop is safe only if one
    // slot remains for it. deq implies occ >= 1, so this never goes negative.
    assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};

    assign bus.fifo_pop  = !rst && !flush && !bus.fifo_empty && (pending <= 3'd1);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head;

    assign xfer_d = deq ? xfer_q + 1'b1 : xfer_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            xfer_q     <= '0;
        end else begin
            inflight_q <= bus.fifo_pop;
            xfer_q     <= xfer_d;
        end
    end

    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed bench with an upstream FIFO model and a scoreboard of expected
//   output words (queued when words are loaded into the FIFO model).
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] xfer_count;

    fifo_stream_reader_if #(.WIDTH(8)) ifc ();

    fifo_stream_reader #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .xfer_count (xfer_count),
        .bus        (ifc)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: 1-cycle read latency, flags from pointer registers
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       underflow = 1'b0;

    assign ifc.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (ifc.fifo_pop) begin
            if (rd_ptr == wr_ptr) begin
                underflow <= 1'b1;
            end else begin
                ifc.fifo_q <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1;
            end
        end
    end

    logic [7:0] exp_q [$];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic       last_pop;
    logic       last_valid;
    logic [7:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [7:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    // One clock: sample at the falling edge, score any transfer, step past
    // the rising edge.
    task automatic cycle();
        logic [7:0] e;
        @(negedge clk);
        last_pop   = ifc.fifo_pop;
        last_valid = ifc.out_valid;
        last_data  = ifc.out_data;
        if (ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_word", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(ifc.out_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pops;
        logic [7:0] vals;
        int         npop;

        rst           = 1'b1;
        flush         = 1'b0;
        ifc.out_ready = 1'b0;

        // Reset and idle with an empty FIFO
        cycle();
        cycle();
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_data", 32'(ifc.out_data), 32'd0);
        chk("rst_xfer", xfer_count, 32'd0);
        chk("rst_pop", 32'(ifc.fifo_pop), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("idle_pop", 32'(last_pop), 32'd0);
            chk("idle_valid", 32'(last_valid), 32'd0);
            chk("idle_xfer", xfer_count, 32'd0);
        end

        // Full-rate streaming
        ifc.out_ready = 1'b1;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        pops = '0;
        vals = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            pops[i] = last_pop;
            vals[i] = last_valid;
        end
        chk("stream_pop_pattern", 32'(pops), 32'h0F);
        chk("stream_valid_pattern", 32'(vals), 32'h3C);
        chk("stream_xfer", xfer_count, 32'd4);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Downstream stall: two words buffered, head held stable
        ifc.out_ready = 1'b0;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        npop = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            npop += int'(last_pop);
            if (i >= 2) begin
                chk("stall_valid", 32'(last_valid), 32'd1);
                chk("stall_data", 32'(last_data), 32'h11);
            end
        end
        chk("stall_pops", 32'(npop), 32'd2);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("stall_xfer", xfer_count, 32'd8);
        chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

        // Flush with 0x22 buffered and 0x33 in flight; 0x22 leaves in the
        // flush cycle, 0x33 is dropped
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        cycle(); cycle(); cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_pop", 32'(last_pop), 32'd0);
        chk("flush_valid_after", 32'(ifc.out_valid), 32'd0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) cycle();
        chk("flush_xfer", xfer_count, 32'd11);
        chk("flush_sb_empty", 32'(exp_q.size()), 32'd0);

        // Single word with a toggling sink
        load(8'h5A);
        npop = 0;
        for (int i = 0; i < 10; i++) begin
            ifc.out_ready = (i % 2 == 0);
            cycle();
            npop += int'(last_pop);
        end
        chk("single_pops", 32'(npop), 32'd1);
        chk("single_xfer", xfer_count, 32'd12);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream: 0xA1 buffered, 0xA2 in flight
        ifc.out_ready = 1'b0;
        load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_pop", 32'(last_pop), 32'd0);
        chk("midrst_valid", 32'(ifc.out_valid), 32'd0);
        chk("midrst_data", 32'(ifc.out_data), 32'd0);
        chk("midrst_xfer", xfer_count, 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("midrst_xfer_after", xfer_count, 32'd2);
        chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

        chk("no_underflow", 32'(underflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
